// File: rtl/adc_filter_pkg.sv
// rtl/adc_filter_pkg.sv - shared types, sizes and helpers for the ADC moving-average filter
package adc_filter_pkg;

    localparam int DATA_W       = 16;
    localparam int MAX_LOG2_WIN = 5;
    localparam int DECIM_W      = 16;
    localparam int ACC_W        = DATA_W + MAX_LOG2_WIN;
    localparam int HIST_DEPTH   = 2 ** MAX_LOG2_WIN;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [2:0] clamp_k(input logic [2:0] k, input logic [2:0] max_k);
        return (k > max_k) ? max_k : k;
    endfunction

endpackage

// File: rtl/adc_sample_hist.sv
// rtl/adc_sample_hist.sv - circular sample history, combinational read, synchronous write
module adc_sample_hist
    import adc_filter_pkg::*;
#(
    parameter int DATA_W = adc_filter_pkg::DATA_W,
    parameter int DEPTH  = HIST_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // Storage is never reset: entries are only read once the fill count proves they were written.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/adc_avg_filter.sv
// rtl/adc_avg_filter.sv - streaming moving-average and decimation stage for ADC samples
module adc_avg_filter #(
    parameter int DATA_W       = adc_filter_pkg::DATA_W,
    parameter int MAX_LOG2_WIN = adc_filter_pkg::MAX_LOG2_WIN,
    parameter int DECIM_W      = adc_filter_pkg::DECIM_W
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               cfg_enable,
    input  logic [2:0]         cfg_log2_win,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic [DATA_W-1:0]  s_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [DATA_W-1:0]  m_tdata,
    output logic               st_running,
    output logic               st_warm
);

    import adc_filter_pkg::*;

    localparam int ACC_W      = DATA_W + MAX_LOG2_WIN;
    localparam int HIST_DEPTH = 2 ** MAX_LOG2_WIN;
    localparam int AW         = MAX_LOG2_WIN;
    localparam int FILL_W     = MAX_LOG2_WIN + 1;

    state_t                    r_state;
    logic [2:0]                r_k;
    logic [DECIM_W-1:0]        r_decim;
    logic [DECIM_W-1:0]        r_decim_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic [FILL_W-1:0]         r_fill;
    logic [AW-1:0]             r_wr_ptr;
    logic                      r_m_tvalid;
    logic [DATA_W-1:0]         r_m_tdata;

    logic                      w_run;
    logic                      w_s_tready;
    logic                      w_accept;
    logic [FILL_W-1:0]         w_win;
    logic                      w_full;
    logic [AW-1:0]             w_rd_addr;
    logic [DATA_W-1:0]         w_hist_rd;
    logic [DATA_W-1:0]         w_old;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic [FILL_W-1:0]         w_fill_next;
    logic                      w_emit;
    logic                      w_fire;
    logic [DATA_W-1:0]         w_avg;
    logic [2:0]                w_k_clamped;

    assign w_run       = (r_state == RUN);
    assign w_s_tready  = w_run && cfg_enable && (!r_m_tvalid || m_tready);
    assign w_accept    = s_tvalid && w_s_tready;
    assign w_win       = FILL_W'(1) << r_k;
    assign w_full      = (r_fill == w_win);
    assign w_k_clamped = clamp_k(cfg_log2_win, 3'(MAX_LOG2_WIN));

    // With the full 32-deep window the oldest entry sits at wr_ptr itself and is read before being overwritten.
    assign w_rd_addr   = r_wr_ptr - w_win[AW-1:0];
    assign w_old       = w_full ? w_hist_rd : '0;

    assign w_acc_next  = r_acc + ACC_W'(signed'(s_tdata)) - ACC_W'(signed'(w_old));
    assign w_fill_next = w_full ? r_fill : r_fill + FILL_W'(1);
    assign w_emit      = w_accept && (w_fill_next == w_win);
    assign w_fire      = w_emit && (r_decim_cnt == '0);
    assign w_avg       = DATA_W'(w_acc_next >>> r_k);

    adc_sample_hist #(
        .DATA_W (DATA_W),
        .DEPTH  (HIST_DEPTH),
        .AW     (AW)
    ) u_hist (
        .i_clk     (ACLK),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (s_tdata),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_hist_rd)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_decim     <= '0;
            r_decim_cnt <= '0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_enable) begin
                        r_state     <= RUN;
                        r_k         <= w_k_clamped;
                        r_decim     <= cfg_decim;
                        r_decim_cnt <= '0;
                        r_acc       <= '0;
                        r_fill      <= '0;
                        r_wr_ptr    <= '0;
                    end
                end
                RUN: begin
                    if (!cfg_enable) begin
                        r_state    <= IDLE;
                        r_m_tvalid <= 1'b0;
                    end else begin
                        if (w_accept) begin
                            r_acc    <= w_acc_next;
                            r_fill   <= w_fill_next;
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                        end
                        if (w_emit) begin
                            r_decim_cnt <= (r_decim_cnt == '0) ? r_decim : r_decim_cnt - DECIM_W'(1);
                        end
                        // A transfer and a fresh average in the same cycle reload without a bubble.
                        if (w_fire) begin
                            r_m_tvalid <= 1'b1;
                            r_m_tdata  <= w_avg;
                        end else if (m_tready) begin
                            r_m_tvalid <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_tready   = w_s_tready;
    assign m_tvalid   = r_m_tvalid;
    assign m_tdata    = r_m_tdata;
    assign st_running = w_run;
    assign st_warm    = w_full;

endmodule

// File: tb/tb_adc_avg_filter.sv
// tb/tb_adc_avg_filter.sv - directed self-checking bench for adc_avg_filter
module tb_adc_avg_filter;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic [2:0]  cfg_log2_win;
    logic [15:0] cfg_decim;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [15:0] m_tdata;
    logic        st_running;
    logic        st_warm;

    int n_vec;
    int n_fail;

    adc_avg_filter dut (
        .ACLK         (clk),
        .ARESETN      (rst_n),
        .cfg_enable   (cfg_enable),
        .cfg_log2_win (cfg_log2_win),
        .cfg_decim    (cfg_decim),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .st_running   (st_running),
        .st_warm      (st_warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic configure(input int k, input int decim);
        cfg_enable = 1'b0;
        tick();
        tick();
        cfg_log2_win = 3'(k);
        cfg_decim    = 16'(decim);
        cfg_enable   = 1'b1;
        tick();
    endtask

    task automatic push(input logic [15:0] x);
        int n;
        n        = 0;
        s_tdata  = x;
        s_tvalid = 1'b1;
        while (s_tready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", {15'b0, s_tready}, 16'h0001);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic [15:0] x, input logic ev, input logic [15:0] ed);
        push(x);
        chk({tag, "_valid"}, {15'b0, m_tvalid}, {15'b0, ev});
        if (ev) chk({tag, "_data"}, m_tdata, ed);
    endtask

    initial begin
        n_vec        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        cfg_enable   = 1'b0;
        cfg_log2_win = '0;
        cfg_decim    = '0;
        s_tvalid     = 1'b0;
        s_tdata      = '0;
        m_tready     = 1'b1;
        tick();
        tick();
        chk("rst_s_tready", {15'b0, s_tready}, 16'h0);
        chk("rst_m_tvalid", {15'b0, m_tvalid}, 16'h0);
        chk("rst_m_tdata", m_tdata, 16'h0);
        chk("rst_running", {15'b0, st_running}, 16'h0);
        chk("rst_warm", {15'b0, st_warm}, 16'h0);
        rst_n = 1'b1;
        tick();

        // 1: k=2 window of 4, every average emitted
        configure(2, 0);
        chk("t1_running", {15'b0, st_running}, 16'h1);
        push_exp("t1_s4", 16'd4, 1'b0, 16'd0);
        push_exp("t1_s8", 16'd8, 1'b0, 16'd0);
        push_exp("t1_s12", 16'd12, 1'b0, 16'd0);
        chk("t1_warm_before", {15'b0, st_warm}, 16'h0);
        push_exp("t1_s16", 16'd16, 1'b1, 16'd10);
        chk("t1_warm_after", {15'b0, st_warm}, 16'h1);
        push_exp("t1_s20", 16'd20, 1'b1, 16'd14);

        // 2: negative averages floor toward minus infinity
        configure(1, 0);
        push_exp("t2_a", 16'hFFFD, 1'b0, 16'd0);
        push_exp("t2_b", 16'hFFFC, 1'b1, 16'hFFFC);
        push_exp("t2_c", 16'hFFFC, 1'b1, 16'hFFFC);
        push_exp("t2_d", 16'hFFFC, 1'b1, 16'hFFFC);

        // 3: passthrough with decimation by 3
        configure(0, 2);
        for (int i = 1; i <= 7; i++) begin
            push_exp($sformatf("t3_s%0d", i), 16'(i), ((i - 1) % 3) == 0, 16'(i));
        end

        // 4: downstream stall holds one output and back-pressures the input
        configure(0, 0);
        m_tready = 1'b0;
        push_exp("t4_first", 16'd11, 1'b1, 16'd11);
        chk("t4_stalled_ready", {15'b0, s_tready}, 16'h0);
        s_tdata  = 16'd22;
        s_tvalid = 1'b1;
        tick();
        tick();
        tick();
        chk("t4_hold_valid", {15'b0, m_tvalid}, 16'h1);
        chk("t4_hold_data", m_tdata, 16'd11);
        chk("t4_hold_ready", {15'b0, s_tready}, 16'h0);
        m_tready = 1'b1;
        tick();
        s_tvalid = 1'b0;
        chk("t4_reload_valid", {15'b0, m_tvalid}, 16'h1);
        chk("t4_reload_data", m_tdata, 16'd22);
        tick();
        chk("t4_no_dup", {15'b0, m_tvalid}, 16'h0);

        // 5: config ignored while running, flush on disable, new window on re-enable
        configure(2, 0);
        push_exp("t5_s1", 16'd1, 1'b0, 16'd0);
        push_exp("t5_s2", 16'd2, 1'b0, 16'd0);
        push_exp("t5_s3", 16'd3, 1'b0, 16'd0);
        push_exp("t5_s4", 16'd4, 1'b1, 16'd2);
        cfg_log2_win = 3'd3;
        push_exp("t5_s5", 16'd5, 1'b1, 16'd3);
        push_exp("t5_s6", 16'd6, 1'b1, 16'd4);
        cfg_enable = 1'b0;
        tick();
        chk("t5_flush_valid", {15'b0, m_tvalid}, 16'h0);
        chk("t5_idle", {15'b0, st_running}, 16'h0);
        cfg_enable = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            push_exp($sformatf("t5_w8_s%0d", i), 16'(i), i == 8, 16'd4);
        end

        // 6: full-scale input over the largest window (requested k clamps to 5)
        configure(7, 0);
        for (int i = 0; i < 40; i++) begin
            push_exp($sformatf("t6_s%0d", i), 16'h7FFF, i >= 31, 16'h7FFF);
        end
        rst_n = 1'b0;
        #1;
        chk("t6_rst_s_tready", {15'b0, s_tready}, 16'h0);
        chk("t6_rst_m_tvalid", {15'b0, m_tvalid}, 16'h0);
        chk("t6_rst_m_tdata", m_tdata, 16'h0);
        chk("t6_rst_running", {15'b0, st_running}, 16'h0);
        chk("t6_rst_warm", {15'b0, st_warm}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
